// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: each winner holds a registered one-hot grant for up
// to weight[i] cycles, then priority rotates to the channel after it.
module wrr_burst_arbiter #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 32,
    parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       request,
    input  logic [CHANNELS*WIDTH-1:0] weight,
    input  logic                      wrr_en,
    output logic [CHANNELS-1:0]       grant,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      grant_valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [IDX_W:0]   CHAN_CNT = (IDX_W+1)'(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [IDX_W-1:0]    base, next_ptr, winner, grant_id_n;
    logic [WIDTH-1:0]    credit, credit_n, load_val;
    logic [CHANNELS-1:0] grant_n;
    logic                found, burst_end, start;
    logic [IDX_W:0]      sum;
    logic [WIDTH-1:0]    weight_arr [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_weight
        assign weight_arr[i] = weight[i*WIDTH +: WIDTH];
    end

    assign next_ptr  = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    assign burst_end = (credit == WIDTH'(1)) || !request[grant_id];
    // At burst end the search starts just past the owner, making it lowest priority.
    assign base      = (state == BUSY) ? next_ptr : ptr;

    // Circular priority search; scanning offsets downward lets the closest requester win.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            sum = {1'b0, base} + (IDX_W+1)'(k);
            if (sum >= CHAN_CNT)
                sum = sum - CHAN_CNT;
            if (request[sum[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[IDX_W-1:0];
            end
        end
    end

    // Weight 0 and plain mode both degrade to a single-cycle burst.
    assign load_val = (wrr_en && weight_arr[winner] != '0) ? weight_arr[winner] : WIDTH'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        credit_n   = credit;
        grant_n    = grant;
        grant_id_n = grant_id;
        start      = 1'b0;
        case (state)
            IDLE: start = found;
            BUSY: begin
                if (!burst_end) begin
                    credit_n = credit - 1'b1;
                end else begin
                    ptr_n = next_ptr;
                    if (found) begin
                        start = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        grant_n    = '0;
                        grant_id_n = '0;
                        credit_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n         = BUSY;
            grant_n         = '0;
            grant_n[winner] = 1'b1;
            grant_id_n      = winner;
            credit_n        = load_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            credit      <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            credit      <= credit_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            grant_valid <= |grant_n;
        end
    end

endmodule

// File: doc/wrr_burst_arbiter.md
Name: wrr_burst_arbiter

Overview:
Parametrised weighted round-robin arbiter with registered one-hot grant. Each winner holds the grant for a burst of up to weight[i] consecutive cycles, then rotates to the next channel. A runtime mode input selects weighted bursts or plain single-cycle round-robin. It replaces the separate mux, next-grant and grant-calc arrangement in the arbitration path with one self-contained block.

Parameters:
CHANNELS, 8, number of requesters (≥1)
WIDTH, 32, width of each per-channel weight and of the internal credit counter
IDX_W, $clog2(CHANNELS) (min 1), width of grant_id (derived; not to be overridden)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
request  input  CHANNELS  per-channel request level; bit i = channel i
weight  input  CHANNELS*WIDTH  packed weights; channel i occupies bits [i*WIDTH +: WIDTH]
wrr_en  input  1  1 = weighted burst mode, 0 = plain round-robin
grant  output  CHANNELS  registered one-hot grant; all-zero when idle
grant_id  output  IDX_W  registered binary index of the granted channel; 0 when idle
grant_valid  output  1  registered; equals |grant

Behaviour:
- Reset (reset==0 at posedge):
  - grant=0, grant_id=0, grant_valid=0.
  - Pointer ptr=0, credit=0, state=IDLE.
  - Reset overrides everything, including mid-burst.
- Winner selection (combinational):
  - Search circularly from ptr: ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1.
  - The winner is the first channel with request=1.
- Load value for a new grant:
  - If wrr_en=1 and weight[winner]≠0: L = weight[winner].
  - Otherwise L = 1. Weight 0 is treated as 1.
  - Weight and wrr_en are sampled only at the grant-start edge. Changes during a burst are ignored.
- IDLE:
  - If |request at posedge: grant←onehot(winner), grant_id←winner, credit←L, state→BUSY.
  - Latency: request high before edge N gives grant visible after edge N (one cycle).
  - If no request: outputs stay zero.
- BUSY, owner o = grant_id. At each posedge, the burst ends if credit==1 or request[o]==0; otherwise credit←credit-1 and the grant is held.
- On burst end:
  - ptr←(o+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - The winner is recomputed from the new ptr in the same cycle, so o is the lowest priority.
  - If a winner exists: regrant back-to-back with no idle bubble, loading credit with that winner's L.
  - If o is the only requester, o is regranted.
  - If no winner: grant cleared and state→IDLE.
- Request drop: a grant cycle in which request[o]=0 is still driven (wasted). Termination takes effect at the following edge.
- Burst length: a channel requesting continuously holds the grant exactly L cycles (1 ≤ L ≤ 2^WIDTH−1).
- wrr_en=0: every burst is 1 cycle, which gives pure single-cycle round-robin.
- Invariants: grant is always one-hot or zero; grant_id matches grant; grant_valid==|grant.
- CHANNELS=1: the channel is granted whenever it requests, with bursts of L.
- The credit counter is WIDTH bits wide; no overflow is possible since it only loads and decrements to 1.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset mid-burst: CHANNELS=8, wrr_en=1, weight[2]=5, request=0x04; assert reset (0) at the 3rd grant cycle → grant=0x00, grant_id=0, grant_valid=0 the next cycle. Release reset with request=0x04 held → ch2 is granted again for a full 5 cycles (ptr restarted at 0).
2. Weighted rotation: request=0x0B held, weights ch0=2, ch1=3, ch3=1 → grant sequence 0x01×2, 0x02×3, 0x08×1, then repeats with no idle cycles.
3. Plain mode: wrr_en=0, request=0xFF, weights arbitrary → grant_id cycles 0,1,…,7,0 one per cycle.
4. Early release: weight[4]=10, request=0x10; deassert request[4] on the 4th grant cycle while request[6]=1 → ch4 granted 4 cycles, then 0x40 back-to-back.
5. Zero weight and wrap: weight[7]=0, request=0x81, ptr at 7 → ch7 granted 1 cycle, then ch0 (ptr wraps to 0).
6. Idle and sole requester: request=0 → grant stays 0. Then request=0x20 with weight[5]=3 held for 9 cycles → three consecutive 3-cycle bursts, grant continuously 0x20, grant_valid continuously 1.
